// File: rtl/axis_pkg.sv
// Shared definitions for the packet FIFO: default beat width, beat record
// and a constant-foldable log2 helper.
package axis_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// Stream handshake bundle around the packet FIFO: write side from the mux,
// read side toward the next consumer. The FIFO is the slave modport.
interface axis_pkt_fifo_if
    import axis_pkg::*;
#(
    parameter int DATA_W = axis_pkg::DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// Packet-aware FWFT stream FIFO. Define AXIS_PKT_FIFO_SF_EN for
// store-and-forward (hold each packet until its last beat is stored).
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter  int DATA_W = axis_pkg::DATA_W,
    parameter  int DEPTH  = 16,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    axis_pkt_fifo_if.slave  s,
    output logic [AW:0]     count,
    output logic [AW:0]     pkt_count,
    output logic            oversize
);
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     r_count;
    logic [AW:0]     r_pkt_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_out_valid;
    logic [DATA_W:0] w_rdata;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // No pass-through when full: a pop in the same cycle does not free a slot.
    assign w_push  = s.in_valid && !w_full;
    assign w_pop   = w_out_valid && s.out_ready;

`ifdef AXIS_PKT_FIFO_SF_EN
    logic r_full_q;
    logic r_cut;

    // r_cut keeps an oversize packet flowing until its last beat lands.
    assign w_out_valid = !w_empty && ((r_pkt_count != '0) || w_full || r_cut);
    assign oversize    = w_full && !r_full_q && (r_pkt_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full_q <= 1'b0;
            r_cut    <= 1'b0;
        end else begin
            r_full_q <= w_full;
            if (w_push && s.in_last)
                r_cut <= 1'b0;
            else if (w_full && (r_pkt_count == '0))
                r_cut <= 1'b1;
        end
    end
`else
    assign w_out_valid = !w_empty;
    assign oversize    = 1'b0;
`endif

    axis_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata ({s.in_last, s.in_data}),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            case ({w_push && s.in_last, w_pop && w_rdata[DATA_W]})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign s.in_ready  = !w_full;
    assign s.out_valid = w_out_valid;
    assign s.out_data  = w_rdata[DATA_W-1:0];
    assign s.out_last  = w_rdata[DATA_W];
    assign count       = r_count;
    assign pkt_count   = r_pkt_count;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: beat scoreboard plus occupancy model,
// vector tables for the streaming cases and hand sequences for the corners.
module tb_axis_pkt_fifo;
    import axis_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] count;
    logic [4:0] pkt_count;
    logic       oversize;

    always #5 clk = ~clk;

    axis_pkt_fifo_if #(.DATA_W(8)) bus ();

    axis_pkt_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (bus),
        .count     (count),
        .pkt_count (pkt_count),
        .oversize  (oversize)
    );

    typedef struct {
        bit         iv;
        logic [7:0] d;
        bit         il;
        bit         ordy;
        bit         exp_ov;
        int         exp_cnt;
    } vec_t;

    vec_t  vt [7];
    beat_t sb [$];
    int    passed = 0;
    int    total  = 0;
    bit    m_prev_full = 1'b0;
`ifdef AXIS_PKT_FIFO_SF_EN
    bit    m_cut = 1'b0;
`endif
    bit    s_ov, s_irdy, s_ovs, s_pushed;
    int    s_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int pkts();
        int n = 0;
        foreach (sb[i]) if (sb[i].last) n++;
        return n;
    endfunction

    // Drive one cycle of inputs, sample at the falling edge, update the model.
    task automatic step(input bit iv, input logic [7:0] d, input bit il, input bit ordy);
        int    sz, np;
        bit    full, exp_ov, push, pop;
        beat_t b;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_last   = il;
        bus.out_ready = ordy;
        @(negedge clk);
        sz   = sb.size();
        np   = pkts();
        full = (sz == DEPTH);
`ifdef AXIS_PKT_FIFO_SF_EN
        exp_ov = (sz != 0) && ((np != 0) || full || m_cut);
        check("oversize", oversize, full && !m_prev_full && (np == 0));
`else
        exp_ov = (sz != 0);
        check("oversize", oversize, 0);
`endif
        check("count", count, sz);
        check("pkt_count", pkt_count, np);
        check("in_ready", bus.in_ready, !full);
        check("out_valid", bus.out_valid, exp_ov);
        s_ov   = bus.out_valid;
        s_irdy = bus.in_ready;
        s_ovs  = oversize;
        s_cnt  = int'(count);
        push   = iv && !full;
        pop    = exp_ov && ordy;
        if (pop) begin
            b = sb.pop_front();
            check("out_data", bus.out_data, b.data);
            check("out_last", bus.out_last, b.last);
        end
        if (push) begin
            b.data = d;
            b.last = il;
            sb.push_back(b);
        end
`ifdef AXIS_PKT_FIFO_SF_EN
        if (push && il) m_cut = 1'b0;
        else if (full && (np == 0)) m_cut = 1'b1;
`endif
        s_pushed    = push;
        m_prev_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", sb.size());
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AXIS_PKT_FIFO_SF_EN
        vt[0] = '{1, 8'h3E, 0, 1, 0, 0};
        vt[1] = '{1, 8'h3F, 0, 1, 0, 1};
        vt[2] = '{1, 8'h40, 1, 1, 0, 2};
        vt[3] = '{0, 8'h00, 0, 1, 1, 3};
        vt[4] = '{0, 8'h00, 0, 1, 1, 2};
        vt[5] = '{0, 8'h00, 0, 1, 1, 1};
        vt[6] = '{0, 8'h00, 0, 1, 0, 0};
`else
        vt[0] = '{1, 8'h01, 0, 1, 0, 0};
        vt[1] = '{1, 8'h02, 0, 1, 1, 1};
        vt[2] = '{1, 8'h03, 0, 1, 1, 1};
        vt[3] = '{1, 8'h04, 0, 1, 1, 1};
        vt[4] = '{1, 8'h05, 1, 1, 1, 1};
        vt[5] = '{0, 8'h00, 0, 1, 1, 1};
        vt[6] = '{0, 8'h00, 0, 1, 0, 0};
`endif
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h3E;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b0;

        // Reset held with a beat offered: nothing may be stored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_count", count, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        step(1'b1, 8'h3E, 1'b1, 1'b0);
        check("first_beat_accepted", s_pushed, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("count_after_first", s_cnt, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 7; i++) begin
            step(vt[i].iv, vt[i].d, vt[i].il, vt[i].ordy);
            check($sformatf("vec%0d_out_valid", i), s_ov, vt[i].exp_ov);
            check($sformatf("vec%0d_count", i), s_cnt, vt[i].exp_cnt);
        end

        // Fill to DEPTH with no last; 17th beat waits for a pop; 20th closes the packet.
        for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h4F, 1'b0, 1'b0);
        check("full_in_ready", s_irdy, 0);
        check("full_count", s_cnt, 16);
`ifdef AXIS_PKT_FIFO_SF_EN
        check("oversize_pulse", s_ovs, 1);
        check("oversize_out_valid", s_ov, 1);
`endif
        step(1'b1, 8'h4F, 1'b0, 1'b1);
        check("held_beat_not_taken", s_pushed, 0);
        step(1'b1, 8'h4F, 1'b0, 1'b1);
        check("held_beat_taken", s_pushed, 1);
`ifdef AXIS_PKT_FIFO_SF_EN
        check("oversize_single", s_ovs, 0);
`endif
        step(1'b1, 8'h50, 1'b0, 1'b1);
        step(1'b1, 8'h51, 1'b0, 1'b1);
        step(1'b1, 8'h52, 1'b1, 1'b1);
        drain();

        // Simultaneous push/pop at 8 entries with last beats on both sides.
        for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), (i == 2 || i == 7), 1'b0);
        step(1'b1, 8'h70, 1'b1, 1'b1);
        check("pp0_count", s_cnt, 8);
        step(1'b1, 8'h71, 1'b0, 1'b1);
        check("pp1_count", s_cnt, 8);
        step(1'b1, 8'h72, 1'b1, 1'b1);
        step(1'b1, 8'h73, 1'b0, 1'b1);
        check("pp3_count", s_cnt, 8);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("pp_final_count", s_cnt, 8);
        drain();

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0));
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 8'hEE, 1'b1, 1'b1);
            if (s_pushed) break;
        end
        drain();

        // Asynchronous reset mid-packet discards everything.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_pkt_count", pkt_count, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        sb.delete();
        m_prev_full = 1'b0;
`ifdef AXIS_PKT_FIFO_SF_EN
        m_cut = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
